mips_multicycle: RTL
====================

// Module: mips_multicycle
// PURPOSE
//   Multi-cycle MIPS-lite core; successor to the single-cycle datapath. One shared ALU and one
//   unified instruction/data memory port with a req/ready handshake, so memory latency may vary.
//   Adds addi, illegal-instruction/misalignment halt, and a retired-instruction counter.
//   Top-level CPU block; the memory model attaches outside.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC loaded on reset
//   CNT_W     32             width of retired counter (wraps modulo 2**CNT_W)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   mem_req    out  1      memory access request
//   mem_we     out  1      1 = write (sw), 0 = read (fetch/lw)
//   mem_addr   out  32     byte address, word aligned; 0 when mem_req=0
//   mem_wdata  out  32     store data; 0 when mem_we=0
//   mem_rdata  in   32     read data, valid in the cycle mem_ready=1
//   mem_ready  in   1      access completes at the clock edge where mem_req&mem_ready
//   halted     out  1      core stopped (illegal instr or misaligned access)
//   pc_out     out  32     architectural PC register
//   retired    out  CNT_W  count of completed instructions
// BEHAVIOUR
//   Reset: state=BOOT, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 regs=0, retired=0, halted=0,
//     mem_req=0, mem_we=0. Reset mid-access drops the request; memory must tolerate it.
//   Handshake: mem_req/we/addr/wdata are decoded from state and held stable until mem_ready
//     is sampled high. mem_ready may be high in the same cycle as mem_req (zero wait).
//     mem_ready while mem_req=0 is ignored.
//   States:
//     BOOT  : one idle cycle after reset release -> FETCH.
//     FETCH : req read @PC; on ready: IR<=rdata, PC<=PC+4 -> DECODE.
//     DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2). Unknown opcode/funct -> HALT.
//     EXEC  : R-type: ALUOut<=A op B -> WB. addi: ALUOut<=A+sext -> WB.
//             lw/sw: ALUOut<=A+sext; if sum[1:0]!=0 -> HALT, else -> MEM.
//             beq: if A==B then PC<=ALUOut; retire -> FETCH.
//             j:   PC<={PC[31:28],imm26,2'b00}; retire -> FETCH.
//     MEM   : lw: req read @ALUOut; on ready MDR<=rdata -> WB.
//             sw: req write @ALUOut, wdata=B; on ready retire -> FETCH.
//     WB    : R[rd] (R-type) or R[rt] (addi/lw) <= ALUOut/MDR; retire -> FETCH.
//     HALT  : halted=1, no requests, retired frozen; exit only by reset.
//   Supported: R-type(op 0) funct add 20h, sub 22h, and 24h, or 25h, slt 2Ah;
//     addi 08h, lw 23h, sw 2Bh, beq 04h, j 02h.
//   Arithmetic is 32-bit wrap; no overflow trap. slt is signed compare.
//   Writes to R0 are discarded; R0 always reads 0.
//   "Retire" means retired+1 on the edge that leaves the final state.
//   Zero-wait cycle counts: R/addi 4, lw 5, sw 4, beq 3, j 3. Each wait cycle adds 1.
// STRUCTURE
//   Package mips_pkg: opcode/funct localparams, state enum (BOOT,FETCH,DECODE,EXEC,MEM,WB,HALT),
//     ALU op encoding.
//   One sub-module mc_alu (comb: op, a, b -> y, zero). Regfile and FSM stay inline.
// TESTING
//   1. Reset, zero-wait mem, prog addi $1,$0,5; addi $2,$0,7; add $3,$1,$2
//      -> R3=12, retired=3 after 12 cycles post-BOOT.
//   2. sw $3,8($0); lw $4,8($0), memory with 3 wait states
//      -> write addr 8, data 12; R4=12; req held stable during waits.
//   3. beq $1,$1,+2 at PC 0x10 -> next fetch at 0x1C; beq not taken -> 0x14; j 0x40 -> fetch 0x100.
//   4. Word 0xFC000000 (op 3Fh) or R-type funct 0x03
//      -> halted=1 after DECODE, no further mem_req, retired unchanged.
//   5. lw $5,2($0) -> halted=1, no memory request issued;
//      addi $0,$0,9 then add $6,$0,$0 -> R6=0.
//   6. Assert rst while a FETCH waits on ready -> mem_req=0 at once; after release
//      BOOT then fetch @RESET_PC; retired=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-lite core: opcodes, functs, FSM states, ALU ops.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  function automatic logic is_legal(input logic [31:0] ir);
    case (ir[31:26])
      OP_RTYPE: return ir[5:0] inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational 32-bit ALU shared by every state of the core; slt is a signed compare.
module mc_alu
  import mips_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o,
  output logic        zero_o
);

  // NOTE: combinational outputs get a default before the case so no path leaves them unassigned (no latch).
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
      default: y_o = '0;
    endcase
  end

  assign zero_o = (y_o == 32'd0);

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-lite core with one shared ALU and a single req/ready memory port.
// Register file and control FSM are kept inline; the ALU is the only sub-block.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             halted,
  output logic [31:0]      pc_out,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]      alu_q, alu_d, mdr_q, mdr_d;
  logic [CNT_W-1:0] retired_q;
  logic [31:0]      regs_q [32];

  logic        retire, reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_zero;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  mc_alu u_alu (
    .op_i   (alu_op),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    retire    = 1'b0;
    reg_we    = 1'b0;
    reg_waddr = rt;
    reg_wdata = alu_q;
    alu_op    = ALU_ADD;
    alu_a     = pc_q;
    alu_b     = 32'd4;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_BOOT: state_d = S_FETCH;

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = alu_y;
          state_d = S_DECODE;
        end
      end

      // Branch target is computed speculatively while the operands are read.
      S_DECODE: begin
        a_d     = regs_q[rs];
        b_d     = regs_q[rt];
        alu_b   = {imm_sext[29:0], 2'b00};
        alu_d   = alu_y;
        state_d = is_legal(ir_q) ? S_EXEC : S_HALT;
      end

      S_EXEC: begin
        alu_a = a_q;
        alu_b = imm_sext;
        case (opcode)
          OP_RTYPE: begin
            alu_op  = funct_to_alu(funct);
            alu_b   = b_q;
            alu_d   = alu_y;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = alu_y;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = alu_y;
            state_d = (alu_y[1:0] != 2'b00) ? S_HALT : S_MEM;
          end
          OP_BEQ: begin
            alu_op = ALU_SUB;
            alu_b  = b_q;
            if (alu_zero) pc_d = alu_q;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_q;
        if (opcode == OP_SW) begin
          mem_we    = 1'b1;
          mem_wdata = b_q;
        end
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we    = 1'b1;
        reg_waddr = (opcode == OP_RTYPE) ? rd : rt;
        reg_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_HALT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
      // NOTE: the register file is flop-based and architecturally starts at zero, so it is reset too.
      regs_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (reg_we && reg_waddr != 5'd0) regs_q[reg_waddr] <= reg_wdata;
    end
  end

  assign halted  = (state_q == S_HALT);
  assign pc_out  = pc_q;
  assign retired = retired_q;

endmodule
